// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions for the ID/EX stage: ALU opcodes,
// base opcodes, forward-select encoding and the forwarding priority helper.
package rv_pkg;

    // 4-bit ALU opcode driven into the execute stage
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLT = 4'b0100,
        ALU_XOR = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_LSR = 4'b1000,
        ALU_LSL = 4'b1001,
        ALU_ASR = 4'b1010
    } alu_op_e;

    // RV32I base opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Source of a forwarded register operand
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EXM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // Control bits carried alongside an instruction through EX
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic illegal;
    } ctrl_t;

    // EX/MEM wins over MEM/WB; x0 is hard-wired and never forwards
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic       exm_we,
        input logic [4:0] exm_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        fwd_sel_e sel;
        sel = FWD_REG;
        if (rs != 5'd0) begin
            if (exm_we && (exm_rd == rs)) begin
                sel = FWD_EXM;
            end else if (wb_we && (wb_rd == rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/alu_ctrl.sv
// ALU control decoder: opcode/funct3/funct7[5] to 4-bit ALU opcode plus an
// unsupported-encoding flag. Purely combinational; sits on the ID side.
module alu_ctrl
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_op_e    alu_op,
    output logic       illegal
);

    // Map the instruction encoding onto an ALU operation
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                case (funct3)
                    3'b000: alu_op = ((opcode == OPC_OP) && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op = ALU_LSL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: begin
                        // SLTU has no ALU encoding: fall back to ADD and flag it
                        alu_op  = ALU_ADD;
                        illegal = 1'b1;
                    end
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = funct7_5 ? ALU_ASR : ALU_LSR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JALR: alu_op = ALU_ADD;
            OPC_BRANCH: alu_op = ALU_SUB;
            default: begin
                alu_op  = ALU_ADD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand select.
// Registers decoded fields, drives forwarded ALU operands and detects
// load-use hazards. Optional macro ID_EX_FORWARDING_EN enables EX/MEM and
// MEM/WB forwarding; without it operands come straight from the register
// file read data and every RAW against EX or EX/MEM stalls instead.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic            exm_reg_write,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [3:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_illegal,
    output logic            hazard_stall
);

    // ID-side decode results
    alu_op_e id_alu_op;
    logic    id_illegal;
    ctrl_t   id_ctrl;

    // EX-side registered state
    logic            ex_valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic [6:0]      opcode_q;
    alu_op_e         alu_op_q;
    ctrl_t           ctrl_q;

    // Hazard and forwarding signals
    logic            ex_rd_match;
    logic            load_use;
    logic            raw_stall;
    fwd_sel_e        rs1_sel;
    fwd_sel_e        rs2_sel;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    alu_ctrl u_alu_ctrl (
        .opcode   (id_opcode),
        .funct3   (id_funct3),
        .funct7_5 (id_funct7_5),
        .alu_op   (id_alu_op),
        .illegal  (id_illegal)
    );

    // Derive memory/write-back controls from the ID opcode, gated by id_valid
    always_comb begin
        id_ctrl = '0;
        case (id_opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JALR: id_ctrl.reg_write = 1'b1;
            OPC_LOAD: begin
                id_ctrl.reg_write = 1'b1;
                id_ctrl.mem_read  = 1'b1;
            end
            OPC_STORE: id_ctrl.mem_write = 1'b1;
            default: ;
        endcase
        id_ctrl.illegal = id_illegal;
        if (!id_valid) begin
            id_ctrl = '0;
        end
    end

    // Load-use detection, plus plain RAW stalls when forwarding is absent
    always_comb begin
        ex_rd_match = (rd_q == id_rs1) || (rd_q == id_rs2);
        load_use    = ex_valid_q && ctrl_q.mem_read && (rd_q != 5'd0) &&
                      id_valid && ex_rd_match;
`ifdef ID_EX_FORWARDING_EN
        raw_stall   = 1'b0;
`else
        raw_stall   = id_valid &&
                      ((ex_valid_q && ctrl_q.reg_write && (rd_q != 5'd0) && ex_rd_match) ||
                       (exm_reg_write && (exm_rd != 5'd0) &&
                        ((exm_rd == id_rs1) || (exm_rd == id_rs2))));
`endif
        hazard_stall = !flush && (load_use || raw_stall);
    end

    // Pipeline register: flush > stall > hazard bubble > normal load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too so EX outputs are defined straight out of reset.
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
            alu_op_q   <= ALU_ADD;
            rd_q       <= 5'd0;
            pc_q       <= RESET_PC;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            opcode_q   <= 7'd0;
        end else if (flush) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
        end else if (stall) begin
            ex_valid_q <= ex_valid_q;
        end else if (hazard_stall) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            ex_valid_q <= id_valid;
            ctrl_q     <= id_ctrl;
            alu_op_q   <= id_alu_op;
            rd_q       <= id_rd;
            pc_q       <= id_pc;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            opcode_q   <= id_opcode;
        end
    end

    // Choose the forwarding source for each registered source operand
`ifdef ID_EX_FORWARDING_EN
    assign rs1_sel = fwd_select(rs1_q, exm_reg_write, exm_rd, wb_reg_write, wb_rd);
    assign rs2_sel = fwd_select(rs2_q, exm_reg_write, exm_rd, wb_reg_write, wb_rd);
`else
    assign rs1_sel = FWD_REG;
    assign rs2_sel = FWD_REG;
`endif

    // Forwarding muxes and ALU operand selection
    always_comb begin
        case (rs1_sel)
            FWD_EXM: rs1_fwd = exm_result;
            FWD_WB:  rs1_fwd = wb_data;
            default: rs1_fwd = rs1_data_q;
        endcase
        case (rs2_sel)
            FWD_EXM: rs2_fwd = exm_result;
            FWD_WB:  rs2_fwd = wb_data;
            default: rs2_fwd = rs2_data_q;
        endcase

        ex_op1 = rs1_fwd;
        if (opcode_q == OPC_LUI) begin
            ex_op1 = '0;
        end else if (opcode_q == OPC_AUIPC) begin
            ex_op1 = pc_q;
        end

        case (opcode_q)
            OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JALR: ex_op2 = imm_q;
            default: ex_op2 = rs2_fwd;
        endcase
    end

    assign ex_store_data = rs2_fwd;
    assign ex_valid      = ex_valid_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = ex_valid_q & ctrl_q.reg_write;
    assign ex_mem_read   = ex_valid_q & ctrl_q.mem_read;
    assign ex_mem_write  = ex_valid_q & ctrl_q.mem_write;
    assign ex_illegal    = ex_valid_q & ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage. Expectations follow the
// ID_EX_FORWARDING_EN setting of the build.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] ST_OP  = 7'b0100011;
    localparam logic [6:0] LUI_OP = 7'b0110111;
    localparam logic [6:0] AUI_OP = 7'b0010111;
    localparam logic [6:0] JLR_OP = 7'b1100111;
    localparam logic [6:0] BR_OP  = 7'b1100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall, flush, id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [6:0]      id_opcode;
    logic [2:0]      id_funct3;
    logic            id_funct7_5;
    logic            exm_reg_write, wb_reg_write;
    logic [4:0]      exm_rd, wb_rd;
    logic [XLEN-1:0] exm_result, wb_data;
    logic            ex_valid;
    logic [XLEN-1:0] ex_op1, ex_op2, ex_store_data;
    logic [3:0]      ex_alu_op;
    logic [4:0]      ex_rd;
    logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal, hazard_stall;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_opcode     (id_opcode),
        .id_funct3     (id_funct3),
        .id_funct7_5   (id_funct7_5),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .ex_valid      (ex_valid),
        .ex_op1        (ex_op1),
        .ex_op2        (ex_op2),
        .ex_alu_op     (ex_alu_op),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_illegal    (ex_illegal),
        .hazard_stall  (hazard_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f75;
        logic [3:0] alu;
        logic       ill;
    } dec_vec_t;

    dec_vec_t vecs [19] = '{
        '{R_OP,   3'b000, 1'b1, 4'b0110, 1'b0},
        '{R_OP,   3'b000, 1'b0, 4'b0010, 1'b0},
        '{R_OP,   3'b001, 1'b0, 4'b1001, 1'b0},
        '{R_OP,   3'b010, 1'b0, 4'b0100, 1'b0},
        '{R_OP,   3'b011, 1'b0, 4'b0010, 1'b1},
        '{R_OP,   3'b100, 1'b0, 4'b0101, 1'b0},
        '{R_OP,   3'b101, 1'b0, 4'b1000, 1'b0},
        '{R_OP,   3'b101, 1'b1, 4'b1010, 1'b0},
        '{R_OP,   3'b110, 1'b0, 4'b0001, 1'b0},
        '{R_OP,   3'b111, 1'b0, 4'b0000, 1'b0},
        '{I_OP,   3'b000, 1'b1, 4'b0010, 1'b0},
        '{I_OP,   3'b101, 1'b1, 4'b1010, 1'b0},
        '{I_OP,   3'b101, 1'b0, 4'b1000, 1'b0},
        '{BR_OP,  3'b000, 1'b0, 4'b0110, 1'b0},
        '{LD_OP,  3'b010, 1'b0, 4'b0010, 1'b0},
        '{ST_OP,  3'b010, 1'b0, 4'b0010, 1'b0},
        '{JLR_OP, 3'b000, 1'b0, 4'b0010, 1'b0},
        '{JAL_OP, 3'b000, 1'b0, 4'b0010, 1'b1},
        '{7'd0,   3'b000, 1'b0, 4'b0010, 1'b1}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_id(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                            input logic f75, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [31:0] pc);
        id_valid    = v;
        id_opcode   = opc;
        id_funct3   = f3;
        id_funct7_5 = f75;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_rs1_data = d1;
        id_rs2_data = d2;
        id_imm      = imm;
        id_pc       = pc;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wd);
        exm_reg_write = ew;
        exm_rd        = erd;
        exm_result    = ed;
        wb_reg_write  = ww;
        wb_rd         = wrd;
        wb_data       = wd;
    endtask

    // Advance one rising edge, then sample well away from it
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive_id(1'b0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  32'(ex_valid),     32'd0);
        check("rst_alu",    32'(ex_alu_op),    32'h2);
        check("rst_rd",     32'(ex_rd),        32'd0);
        check("rst_op1",    ex_op1,            32'd0);
        check("rst_rw",     32'(ex_reg_write), 32'd0);
        check("rst_mr",     32'(ex_mem_read),  32'd0);
        check("rst_ill",    32'(ex_illegal),   32'd0);
        check("rst_hazard", 32'(hazard_stall), 32'd0);
        rst_n = 1'b1;

        // SUB x3 = x1 - x2
        drive_id(1'b1, R_OP, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 32'h40);
        step();
        check("sub_valid", 32'(ex_valid),     32'd1);
        check("sub_alu",   32'(ex_alu_op),    32'h6);
        check("sub_op1",   ex_op1,            32'd10);
        check("sub_op2",   ex_op2,            32'd3);
        check("sub_rd",    32'(ex_rd),        32'd3);
        check("sub_rw",    32'(ex_reg_write), 32'd1);

        // Use of x5 with producers in EX/MEM and MEM/WB
        drive_id(1'b1, R_OP, 3'b000, 1'b0, 5'd5, 5'd0, 5'd6, 32'h99, 32'd7, 32'd0, 32'h44);
        step();
        drive_id(1'b0, R_OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        set_fwd(1'b1, 5'd5, 32'h55, 1'b1, 5'd5, 32'h11);
        #1;
        check("fwd_exm_wins", ex_op1, FWD ? 32'h55 : 32'h99);
        check("fwd_op2_reg",  ex_op2, 32'd7);
        exm_reg_write = 1'b0;
        #1;
        check("fwd_wb",       ex_op1, FWD ? 32'h11 : 32'h99);

        // x0 never forwards
        drive_id(1'b1, R_OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd6, 32'h33, 32'h44, 32'd0, 32'h48);
        set_fwd(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h11);
        step();
        check("x0_op1", ex_op1, 32'h33);
        check("x0_op2", ex_op2, 32'h44);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Load-use: LW x7 followed by a reader of x7
        drive_id(1'b1, LD_OP, 3'b010, 1'b0, 5'd1, 5'd0, 5'd7, 32'h1000, 32'd0, 32'd4, 32'h4c);
        step();
        check("lw_mr",  32'(ex_mem_read), 32'd1);
        check("lw_op1", ex_op1,           32'h1000);
        check("lw_op2", ex_op2,           32'd4);
        drive_id(1'b1, R_OP, 3'b000, 1'b0, 5'd7, 5'd2, 5'd8, 32'hdead, 32'd3, 32'd0, 32'h50);
        #1;
        check("lu_hazard", 32'(hazard_stall), 32'd1);
        step();
        check("lu_bubble",      32'(ex_valid),     32'd0);
        check("lu_bubble_rw",   32'(ex_reg_write), 32'd0);
        check("lu_hazard_drop", 32'(hazard_stall), 32'd0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
        step();
        check("lu_issue_valid", 32'(ex_valid), 32'd1);
        check("lu_issue_rd",    32'(ex_rd),    32'd8);
        check("lu_issue_op1",   ex_op1,        FWD ? 32'h77 : 32'hdead);
        check("lu_issue_op2",   ex_op2,        32'd3);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // flush and stall together drop a valid ADDI
        drive_id(1'b1, I_OP, 3'b000, 1'b1, 5'd1, 5'd0, 5'd9, 32'h20, 32'd0, 32'h12, 32'h54);
        flush = 1'b1;
        stall = 1'b1;
        step();
        check("flush_valid", 32'(ex_valid),     32'd0);
        check("flush_rw",    32'(ex_reg_write), 32'd0);
        flush = 1'b0;
        stall = 1'b0;
        step();
        check("addi_valid", 32'(ex_valid),  32'd1);
        check("addi_alu",   32'(ex_alu_op), 32'h2);
        check("addi_op1",   ex_op1,         32'h20);
        check("addi_op2",   ex_op2,         32'h12);

        // stall alone holds everything for three cycles
        stall = 1'b1;
        drive_id(1'b1, R_OP, 3'b000, 1'b1, 5'd0, 5'd0, 5'd4, 32'hAAAA, 32'hBBBB, 32'd0, 32'h58);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold%0d_valid", i), 32'(ex_valid),  32'd1);
            check($sformatf("hold%0d_alu", i),   32'(ex_alu_op), 32'h2);
            check($sformatf("hold%0d_op1", i),   ex_op1,         32'h20);
            check($sformatf("hold%0d_op2", i),   ex_op2,         32'h12);
            check($sformatf("hold%0d_rd", i),    32'(ex_rd),     32'd9);
        end
        stall = 1'b0;

        // AUIPC and LUI operand selection
        drive_id(1'b1, AUI_OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd10, 32'h999, 32'h888, 32'h2000, 32'h100);
        step();
        check("auipc_op1", ex_op1,         32'h100);
        check("auipc_op2", ex_op2,         32'h2000);
        check("auipc_alu", 32'(ex_alu_op), 32'h2);
        drive_id(1'b1, LUI_OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd10, 32'h999, 32'h888, 32'h12345000, 32'h104);
        step();
        check("lui_op1", ex_op1, 32'd0);
        check("lui_op2", ex_op2, 32'h12345000);

        // ALU opcode decode table
        for (int i = 0; i < 19; i++) begin
            drive_id(1'b1, vecs[i].opc, vecs[i].f3, vecs[i].f75, 5'd0, 5'd0, 5'd1,
                     32'd0, 32'd0, 32'd0, 32'h200);
            step();
            check($sformatf("dec%0d_alu", i), 32'(ex_alu_op),  32'(vecs[i].alu));
            check($sformatf("dec%0d_ill", i), 32'(ex_illegal), 32'(vecs[i].ill));
        end

        // Unsupported opcode without a valid instruction is not flagged
        drive_id(1'b0, JAL_OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 32'h204);
        step();
        check("inv_ill",   32'(ex_illegal), 32'd0);
        check("inv_valid", 32'(ex_valid),   32'd0);

        // ADD x5 then a reader of x5
        drive_id(1'b1, R_OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'd0, 32'h300);
        step();
        drive_id(1'b1, R_OP, 3'b000, 1'b1, 5'd5, 5'd0, 5'd6, 32'h55, 32'h5, 32'd0, 32'h304);
        #1;
`ifdef ID_EX_FORWARDING_EN
        check("raw_no_stall", 32'(hazard_stall), 32'd0);
        step();
        check("raw_issue_valid", 32'(ex_valid), 32'd1);
`else
        check("raw_stall_ex", 32'(hazard_stall), 32'd1);
        step();
        check("raw_bubble1", 32'(ex_valid), 32'd0);
        set_fwd(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0);
        #1;
        check("raw_stall_exm", 32'(hazard_stall), 32'd1);
        step();
        check("raw_bubble2", 32'(ex_valid), 32'd0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55);
        #1;
        check("raw_stall_wb", 32'(hazard_stall), 32'd0);
        step();
        check("raw_issue_valid", 32'(ex_valid), 32'd1);
`endif
        check("raw_issue_op1", ex_op1,         32'h55);
        check("raw_issue_alu", 32'(ex_alu_op), 32'h6);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Asynchronous reset in the middle of a cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ex_valid),     32'd0);
        check("arst_alu",   32'(ex_alu_op),    32'h2);
        check("arst_rd",    32'(ex_rd),        32'd0);
        check("arst_rw",    32'(ex_reg_write), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the ALU.
- Latches decoded instruction fields and generates the 4-bit ALU opcode from opcode/funct3/funct7[5].
- Drives ALU op1/op2 with EX/MEM and MEM/WB forwarding, and detects load-use hazards by inserting a bubble.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, reset value of the registered PC.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  external hold (memory wait): stage keeps its contents.
- flush  in  1  branch/jump redirect: stage becomes a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_opcode  in  7  instruction opcode.
- id_funct3  in  3  instruction funct3.
- id_funct7_5  in  1  instruction bit 30.
- exm_reg_write  in  1  EX/MEM write enable.
- exm_rd  in  5  EX/MEM destination register.
- exm_result  in  XLEN  EX/MEM result.
- wb_reg_write  in  1  MEM/WB write enable.
- wb_rd  in  5  MEM/WB destination register.
- wb_data  in  XLEN  MEM/WB write-back data.
- ex_valid  out  1  EX holds a real instruction.
- ex_op1, ex_op2  out  XLEN each  ALU operands (combinational from the registered state).
- ex_alu_op  out  4  ALU opcode.
- ex_store_data  out  XLEN  forwarded rs2 for stores.
- ex_rd  out  5  destination register.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  control, gated by ex_valid.
- ex_illegal  out  1  unsupported encoding seen.
- hazard_stall  out  1  load-use hazard: IF/ID must hold.

Behaviour:
- Reset (async, rst_n low): ex_valid=0, all control bits 0, ex_alu_op=ADD (0010), ex_rd=0, data registers 0, PC=RESET_PC. Release is synchronous to clk.
- Register update priority on rising clk: flush > stall > hazard_stall > normal load.
  - flush: valid and all control bits cleared; data registers are don't-care.
  - stall: all registers hold.
  - hazard_stall: bubble loaded (valid=0, controls 0).
  - normal: all fields loaded; controls ANDed with id_valid.
- Latency: one cycle from ID to EX outputs. The operand muxes are combinational after the register.
- ALU opcode decode (done on the ID side, then registered):
  - R-type (0110011): 000 → SUB if f7_5, else ADD; 001 → LSL; 010 → SLT; 100 → XOR; 101 → ASR if f7_5, else LSR; 110 → OR; 111 → AND; 011 (SLTU) → ADD and ex_illegal=1.
  - I-ALU (0010011): same mapping; f7_5 is used only for 101; 000 is always ADD.
  - Load (0000011), store (0100011), LUI (0110111), AUIPC (0010111), JALR (1100111): ADD.
  - Branch (1100011): SUB.
  - Any other opcode: ADD and ex_illegal=1 (only when valid).
- Operand select:
  - op1 = 0 for LUI, registered PC for AUIPC, otherwise fwd(rs1).
  - op2 = registered imm for I-ALU/load/store/LUI/AUIPC/JALR, otherwise fwd(rs2).
  - ex_store_data = fwd(rs2) always.
- Forwarding fwd(rsN):
  - If exm_reg_write and exm_rd==rsN and rsN!=0: exm_result.
  - Else if wb_reg_write and wb_rd==rsN and rsN!=0: wb_data.
  - Else: registered read data.
  - EX/MEM has priority when both match. x0 never forwards.
- hazard_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2). It is combinational; flush masks it.
- Reset mid-operation: contents are discarded immediately with no completion.

Optional Feature:
- Macro: ID_EX_FORWARDING_EN.
- Defined: forwarding as described above.
- Undefined: fwd(rsN) returns the registered read data only. hazard_stall additionally asserts when any valid RAW match exists against EX (ex_reg_write) or EX/MEM (exm_reg_write) for a nonzero rd. The register file is write-first, so WB needs no stall.

Decomposition:
- Shared package rv_pkg holds:
  - ALU opcode constants AND=0000, OR=0001, ADD=0010, SLT=0100, XOR=0101, SUB=0110, LSR=1000, LSL=1001, ASR=1010.
  - RISC-V opcode constants.
  - A 2-bit forward-select type.
- One sub-module, alu_ctrl: combinational opcode/funct3/f7_5 → alu_op plus illegal. It is instantiated on the ID side of the register.

Test Plan:
- R-type SUB x3=x1-x2 (f7_5=1, funct3 000), rs data 10/3 → next cycle ex_alu_op=0110, op1=10, op2=3, ex_valid=1.
- Back-to-back ADD x5 then use x5, exm_rd=5, exm_result=0x55, wb_rd=5, wb_data=0x11 → op1=0x55 (EX/MEM wins). With rs1=0 and exm_rd=0 → op1 = registered data 0.
- LW x7 in EX, ID reads x7 → hazard_stall=1 for one cycle, bubble (ex_valid=0) next cycle, then instruction issues with op forwarded from wb_data.
- flush and stall asserted together with a valid ADDI → ex_valid=0 next cycle. stall alone → all outputs unchanged for 3 held cycles.
- AUIPC with pc=0x100, imm=0x2000 → op1=0x100, op2=0x2000, alu_op=0010. SRAI (funct3 101, f7_5=1) → 1010. funct3 011 R-type → ex_illegal=1.
- Assert rst_n low mid-stream → ex_valid=0, ex_alu_op=0010 immediately without a clock edge. Without ID_EX_FORWARDING_EN, the ADD-then-use pair stalls for 2 cycles.
